// File: rtl/dsc_mul_sched.sv
// dsc_mul_sched: round-robin request scheduler and sequencer for a shared
// 2-input deterministic stochastic-computing multiplier core. Accepts an
// operand pair, clears and runs the core for one stream period (or until the
// core raises its shutoff flag), then returns the captured count with the
// requester id.
//
// Handshake semantics (all ports): a transfer happens on a rising edge where
// valid and ready are both high. A source holds valid and payload stable until
// the transfer; ready may be asserted without valid and carries no meaning on
// its own.
module dsc_mul_sched #(
    parameter int SNG_WIDTH = 6,
    parameter int ZW        = 2 * SNG_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic [SNG_WIDTH-1:0] req0_a,
    input  logic [SNG_WIDTH-1:0] req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [SNG_WIDTH-1:0] req1_a,
    input  logic [SNG_WIDTH-1:0] req1_b,
    output logic                 req1_ready,
    output logic [SNG_WIDTH-1:0] core_a,
    output logic [SNG_WIDTH-1:0] core_b,
    output logic                 core_rst,
    output logic                 core_en,
    input  logic [ZW-1:0]        core_z,
    input  logic                 core_ov,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ZW-1:0]        rsp_z,
    output logic                 rsp_id,
    output logic                 rsp_early,
    output logic                 busy,
    output logic [2:0]           dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Last RUN cycle of a full period: counter starts at 0 on the first RUN cycle.
    localparam logic [ZW-1:0] CNT_LAST = '1;

    state_t               state_q;
    logic                 last_q;
    logic                 id_q;
    logic                 early_q;
    logic [ZW-1:0]        cnt_q;
    logic [ZW-1:0]        cnt_d;
    logic [SNG_WIDTH-1:0] core_a_q;
    logic [SNG_WIDTH-1:0] core_b_q;
    logic [ZW-1:0]        rsp_z_q;
    logic                 rsp_early_q;

    logic                 grant0;
    logic                 grant1;
    logic                 accept;
    logic                 sel_id;
    logic [SNG_WIDTH-1:0] sel_a;
    logic [SNG_WIDTH-1:0] sel_b;

    // Round-robin grant: a lone requester wins; on contention the one that
    // was not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    assign req0_ready = !rst && (state_q == S_IDLE) && grant0;
    assign req1_ready = !rst && (state_q == S_IDLE) && grant1;
    assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    assign sel_id     = grant1;
    assign sel_a      = grant1 ? req1_a : req0_a;
    assign sel_b      = grant1 ? req1_b : req0_b;
    assign cnt_d      = cnt_q + 1'b1;

    // Sequencer: accept, clear the core, run the stream, let the final count
    // settle, then hold the response until it is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            id_q        <= 1'b0;
            early_q     <= 1'b0;
            cnt_q       <= '0;
            core_a_q    <= '0;
            core_b_q    <= '0;
            rsp_z_q     <= '0;
            rsp_early_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        core_a_q <= sel_a;
                        core_b_q <= sel_b;
                        id_q     <= sel_id;
                        last_q   <= sel_id;
                        if (sel_a == '0 || sel_b == '0) begin
                            // Product is known to be zero: skip the core.
                            rsp_z_q     <= '0;
                            rsp_early_q <= 1'b1;
                            state_q     <= S_RESP;
                        end else begin
                            state_q <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    cnt_q   <= '0;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    cnt_q <= cnt_d;
                    if (core_ov) begin
                        early_q <= 1'b1;
                        state_q <= S_DRAIN;
                    end else if (cnt_q == CNT_LAST) begin
                        early_q <= 1'b0;
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    rsp_z_q     <= core_z;
                    rsp_early_q <= early_q;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign core_a    = core_a_q;
    assign core_b    = core_b_q;
    assign core_rst  = rst || (state_q == S_CLR);
    assign core_en   = (state_q == S_RUN);
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_z     = rsp_z_q;
    assign rsp_id    = id_q;
    assign rsp_early = rsp_early_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/dsc_mul_sched.md
# dsc_mul_sched

Request scheduler and sequencer for a shared 2-input deterministic stochastic-computing (DSC) multiplier core. Two requesters submit binary operand pairs over valid/ready. The block arbitrates round-robin between them, loads the operands into the core, and runs one complete stream period, ending early if the core's shutoff flag rises. It then captures the stochastic-to-binary count and returns it over a valid/ready response port, tagged with the requester ID.

## Interface
- `SNG_WIDTH`, default 6: operand width; the core's SNG width.
- `ZW`, default 2*SNG_WIDTH: result width; also the run-counter width.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req0_valid` in 1: requester 0 has an operand pair.
- `req0_a`, `req0_b` in SNG_WIDTH: requester 0 operands; held stable while `req0_valid` is high.
- `req0_ready` out 1: accept strobe for requester 0.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: identical set for requester 1.
- `core_a`, `core_b` out SNG_WIDTH: registered operands driven to the core.
- `core_rst` out 1: core reset.
- `core_en` out 1: core enable.
- `core_z` in ZW: core output count.
- `core_ov` in 1: core early-shutoff / stream-end flag.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_z` out ZW: captured product count.
- `rsp_id` out 1: ID of the requester that owns `rsp_z`.
- `rsp_early` out 1: run ended by `core_ov` or by the zero shortcut, not by the full period.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, CLR, RUN, DRAIN, RESP. Reset enters IDLE.
- **IDLE:** combinational grant from the valids and the round-robin pointer `last`.
  - If only one valid is high, that requester is granted.
  - If both are high, the requester other than `last` is granted.
  - `reqN_ready` = (state==IDLE) & grantN. At most one ready is high in any cycle.
- **Accept** (valid & ready):
  - Latch a, b and id into `core_a`, `core_b` and the id register.
  - Set `last` := id.
  - If a==0 or b==0 (zero shortcut): load `rsp_z`=0, set `rsp_early`=1, go to RESP.
  - Otherwise go to CLR.
- **CLR:** `core_rst`=1, `core_en`=0, run counter := 0. Lasts one cycle, then RUN.
- **RUN:** `core_en`=1, run counter +1 per cycle. `core_ov` is sampled every RUN cycle, including the first.
  - If `core_ov`=1, set the early flag and go to DRAIN.
  - Else if the counter equals 2^ZW−1 (2^ZW RUN cycles completed), early flag = 0 and go to DRAIN.
  - If both conditions hold in the same cycle, the early flag = 1.
- **DRAIN:** `core_en`=0 for one cycle so the core's final count update settles. At the end of DRAIN, `rsp_z` := `core_z` and `rsp_early` := early flag. Then RESP.
- **RESP:** `rsp_valid`=1. `rsp_z`, `rsp_id` and `rsp_early` stay stable until `rsp_ready`=1; the state then returns to IDLE.
  - No new request is accepted in the handshake cycle; acceptance resumes on the next IDLE cycle.
- `core_rst` = rst | (state==CLR).
- `core_a` and `core_b` hold their last values outside RUN.
- Core stream arithmetic is the core's concern. The scheduler never modifies `core_z`.

## Timing
- **Reset values:** all ready, `rsp_valid`, `rsp_z`, `rsp_id`, `rsp_early`, `core_en`, `core_a`, `core_b` and `busy` = 0. `core_rst`=1 while `rst` is high. `last`=1, so requester 0 wins the first contention.
- **Latency** from accept at cycle T:
  - CLR at T+1.
  - RUN from T+2 through T+1+N, where N is the number of RUN cycles (1..2^ZW).
  - DRAIN at T+2+N.
  - `rsp_valid` rises at T+3+N. Full period with ZW=12: T+4099.
- **Zero shortcut:** `rsp_valid` rises at T+1. The core is not touched.
- **Throughput:** the next accept happens no earlier than one cycle after the response handshake.
- **Reset mid-operation:** reset in any state returns the block to IDLE on the next edge. The in-flight request is discarded, no response is issued, and `last` returns to 1.
- A requester that drops valid before ready is not granted and does not move `last`.

## Test plan
- **Full run:** req0 a=32, b=32, `core_ov` held 0, `rsp_ready`=1. Expected: `core_en` high for exactly 4096 cycles; `rsp_valid` at accept+4099; `rsp_z`=`core_z` at end of DRAIN; `rsp_id`=0; `rsp_early`=0.
- **Zero shortcut:** req1 a=0, b=17. Expected: `req1_ready` pulse; `rsp_valid` next cycle; `rsp_z`=0, `rsp_id`=1, `rsp_early`=1; `core_en` never asserted.
- **Early shutoff:** req0 a=5, b=9, `core_ov` pulsed on the 100th RUN cycle. Expected: DRAIN next cycle; `rsp_valid` at accept+103; `rsp_early`=1.
- **Contention:** both valids held for three requests each. Expected: grant order 0,1,0,1,0,1; never two readies in one cycle.
- **Backpressure:** `rsp_ready`=0 for 20 cycles after `rsp_valid`. Expected: `rsp_z`, `rsp_id` and `rsp_early` stable; no ready asserted; IDLE one cycle after `rsp_ready`=1.
- **Reset mid-RUN:** `rst` pulsed at RUN cycle 50. Expected: the next cycle shows IDLE with all outputs at reset values, no `rsp_valid`, and req0 winning the next contention.
